// File: rtl/ama_riscv_defines.sv
// Shared RV32I decode definitions for the ID stage: opcodes, immediate-generator
// select encoding and the ID controller state type.
package ama_riscv_defines;

  localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPC_STORE    = 7'b010_0011;
  localparam logic [6:0] OPC_OP       = 7'b011_0011;
  localparam logic [6:0] OPC_LUI      = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPC_JALR     = 7'b110_0111;
  localparam logic [6:0] OPC_JAL      = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

  typedef enum logic [2:0] {
    IG_DISABLED,
    IG_I_TYPE,
    IG_S_TYPE,
    IG_B_TYPE,
    IG_J_TYPE,
    IG_U_TYPE
  } ig_sel_t;

  typedef enum logic [1:0] {
    EMPTY,
    RUN,
    HOLD,
    BUBBLE
  } id_state_t;

  typedef struct packed {
    ig_sel_t ig_sel;
    logic    uses_rs1;
    logic    uses_rs2;
    logic    is_load;
    logic    illegal;
  } id_dec_t;

endpackage

// File: rtl/ama_riscv_id_ctrl_if.sv
// IF -> ID -> EX handshake bundle plus immediate-generator controls.
// master is the surrounding pipeline, slave is the ID controller.
interface ama_riscv_id_ctrl_if #(
  parameter int unsigned PC_W = 32
) ();
  import ama_riscv_defines::*;

  logic            flush;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_inst;
  logic [PC_W-1:0] if_pc;
  ig_sel_t         ig_sel;
  logic [24:0]     ig_d;
  logic            ex_valid;
  logic            ex_ready;
  logic [31:0]     ex_inst;
  logic [PC_W-1:0] ex_pc;
  logic            ex_illegal;

  modport master (
    output flush, if_valid, if_inst, if_pc, ex_ready,
    input  if_ready, ig_sel, ig_d, ex_valid, ex_inst, ex_pc, ex_illegal
  );

  modport slave (
    input  flush, if_valid, if_inst, if_pc, ex_ready,
    output if_ready, ig_sel, ig_d, ex_valid, ex_inst, ex_pc, ex_illegal
  );

endinterface

// File: rtl/ama_riscv_id_decode.sv
// Combinational opcode decode: immediate format, register usage, load flag and
// RV32I legality.
module ama_riscv_id_decode
  import ama_riscv_defines::*;
(
  input  logic [6:0] opc_i,
  output id_dec_t    dec_o
);

  always_comb begin
    dec_o = '{ig_sel: IG_DISABLED, uses_rs1: 1'b0, uses_rs2: 1'b0, is_load: 1'b0,
              illegal: 1'b0};
    unique case (opc_i)
      OPC_LOAD: begin
        dec_o.ig_sel   = IG_I_TYPE;
        dec_o.uses_rs1 = 1'b1;
        dec_o.is_load  = 1'b1;
      end
      OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
        dec_o.ig_sel   = IG_I_TYPE;
        dec_o.uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        dec_o.ig_sel   = IG_S_TYPE;
        dec_o.uses_rs1 = 1'b1;
        dec_o.uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        dec_o.ig_sel   = IG_B_TYPE;
        dec_o.uses_rs1 = 1'b1;
        dec_o.uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        dec_o.uses_rs1 = 1'b1;
        dec_o.uses_rs2 = 1'b1;
      end
      OPC_JAL:            dec_o.ig_sel = IG_J_TYPE;
      OPC_LUI, OPC_AUIPC: dec_o.ig_sel = IG_U_TYPE;
      OPC_MISC_MEM:       dec_o.ig_sel = IG_DISABLED;
      default:            dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ama_riscv_id_ctrl.sv
// Decode-stage controller: ID pipeline register, IF/EX handshakes, immediate
// generator sequencing and single-bubble load-use hazard insertion.
module ama_riscv_id_ctrl
  import ama_riscv_defines::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ama_riscv_id_ctrl_if.slave bus
);

  id_state_t       state_q, state_d;
  logic            id_valid_q, id_valid_d;
  logic            id_new_q, id_new_d;
  logic            load_pending_q, load_pending_d;
  logic [4:0]      load_rd_q, load_rd_d;
  logic [31:0]     id_inst_q, id_inst_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  id_dec_t         id_dec_q, id_dec_d, if_dec;

  logic ex_valid, ex_fire, if_ready, if_fire, hazard_d;

  // Decode on the way in so hazard state for the next cycle is known at the edge.
  ama_riscv_id_decode u_decode (
    .opc_i (bus.if_inst[6:0]),
    .dec_o (if_dec)
  );

  assign ex_valid = !bus.flush && (state_q == RUN || state_q == HOLD);
  assign ex_fire  = ex_valid && bus.ex_ready;
  assign if_ready = !bus.flush && (!id_valid_q || ex_fire);
  assign if_fire  = bus.if_valid && if_ready;

  always_comb begin
    id_inst_d      = id_inst_q;
    id_pc_d        = id_pc_q;
    id_dec_d       = id_dec_q;
    id_valid_d     = id_valid_q;
    id_new_d       = if_fire;
    load_pending_d = load_pending_q;
    load_rd_d      = load_rd_q;
    state_d        = state_q;

    if (if_fire) begin
      id_inst_d  = bus.if_inst;
      id_pc_d    = bus.if_pc;
      id_dec_d   = if_dec;
      id_valid_d = 1'b1;
    end else if (ex_fire) begin
      id_valid_d = 1'b0;
    end

    if (ex_fire) begin
      load_pending_d = id_dec_q.is_load && (id_inst_q[11:7] != 5'd0);
      if (load_pending_d) load_rd_d = id_inst_q[11:7];
    end else if (state_q == BUBBLE || (state_q == EMPTY && bus.ex_ready)) begin
      load_pending_d = 1'b0;
    end

    hazard_d = load_pending_d && id_valid_d &&
               ((id_dec_d.uses_rs1 && id_inst_d[19:15] == load_rd_d) ||
                (id_dec_d.uses_rs2 && id_inst_d[24:20] == load_rd_d));

    if (!id_valid_d)                   state_d = EMPTY;
    else if (hazard_d)                 state_d = BUBBLE;
    else if (ex_valid && !bus.ex_ready) state_d = HOLD;
    else                               state_d = RUN;

    if (bus.flush) begin
      id_valid_d     = 1'b0;
      id_new_d       = 1'b0;
      load_pending_d = 1'b0;
      state_d        = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= EMPTY;
      id_valid_q     <= 1'b0;
      id_new_q       <= 1'b0;
      load_pending_q <= 1'b0;
      load_rd_q      <= 5'd0;
      id_inst_q      <= 32'd0;
      id_pc_q        <= '0;
      id_dec_q       <= '0;
    end else begin
      state_q        <= state_d;
      id_valid_q     <= id_valid_d;
      id_new_q       <= id_new_d;
      load_pending_q <= load_pending_d;
      load_rd_q      <= load_rd_d;
      id_inst_q      <= id_inst_d;
      id_pc_q        <= id_pc_d;
      id_dec_q       <= id_dec_d;
    end
  end

  // Select is pulsed once per new instruction; the generator holds its output after that.
  assign bus.ig_sel     = (id_valid_q && id_new_q) ? id_dec_q.ig_sel : IG_DISABLED;
  assign bus.ig_d       = id_inst_q[31:7];
  assign bus.if_ready   = if_ready;
  assign bus.ex_valid   = ex_valid;
  assign bus.ex_inst    = id_inst_q;
  assign bus.ex_pc      = id_pc_q;
  assign bus.ex_illegal = id_valid_q && id_dec_q.illegal;

endmodule

// File: tb/tb_ama_riscv_id_ctrl.sv
// Directed self-checking bench for ama_riscv_id_ctrl, with a small reference
// immediate generator driven by the controller's ig_sel/ig_d outputs.
module tb_ama_riscv_id_ctrl;
  import ama_riscv_defines::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  ama_riscv_id_ctrl_if #(.PC_W(32)) bus ();

  ama_riscv_id_ctrl #(.PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference immediate generator: decodes when selected, otherwise repeats.
  logic [31:0] gen_q, gen_imm;

  function automatic logic [31:0] imm_of(ig_sel_t s, logic [24:0] d);
    case (s)
      IG_I_TYPE: return {{20{d[24]}}, d[24:13]};
      IG_S_TYPE: return {{20{d[24]}}, d[24:18], d[4:0]};
      IG_B_TYPE: return {{19{d[24]}}, d[24], d[0], d[23:18], d[4:1], 1'b0};
      IG_U_TYPE: return {d[24:5], 12'd0};
      IG_J_TYPE: return {{11{d[24]}}, d[24], d[12:5], d[13], d[23:14], 1'b0};
      default:   return 32'd0;
    endcase
  endfunction

  always_comb gen_imm = (bus.ig_sel == IG_DISABLED) ? gen_q : imm_of(bus.ig_sel, bus.ig_d);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) gen_q <= 32'd0;
    else        gen_q <= gen_imm;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_inst  = 32'd0;
    bus.if_pc    = 32'd0;
    bus.ex_ready = 1'b1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic rdy);
    bus.flush    = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    bus.ex_ready = rdy;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    n_chk++; if (bus.if_ready !== 1'b1) $display("FAIL rst_if_ready: got %b want 1", bus.if_ready); else n_pass++;
    n_chk++; if (bus.ex_valid !== 1'b0) $display("FAIL rst_ex_valid: got %b want 0", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.ig_sel !== IG_DISABLED) $display("FAIL rst_ig_sel: got %0d want %0d", bus.ig_sel, IG_DISABLED); else n_pass++;
    n_chk++; if (bus.ig_d !== 25'd0) $display("FAIL rst_ig_d: got %h want 0", bus.ig_d); else n_pass++;
    n_chk++; if (bus.ex_illegal !== 1'b0) $display("FAIL rst_ex_illegal: got %b want 0", bus.ex_illegal); else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    step();
    n_chk++; if (bus.ex_valid !== 1'b0) $display("FAIL idle_ex_valid: got %b want 0", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.if_ready !== 1'b1) $display("FAIL idle_if_ready: got %b want 1", bus.if_ready); else n_pass++;
  endtask

  task automatic test_single_itype();
    send(32'hFFF0_0093, 32'h100, 1'b1);
    #1;
    n_chk++; if (bus.if_ready !== 1'b1) $display("FAIL itype_accept: got %b want 1", bus.if_ready); else n_pass++;
    step();
    idle();
    #1;
    n_chk++; if (bus.ex_valid !== 1'b1) $display("FAIL itype_ex_valid: got %b want 1", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.ex_inst !== 32'hFFF0_0093) $display("FAIL itype_ex_inst: got %h want fff00093", bus.ex_inst); else n_pass++;
    n_chk++; if (bus.ex_pc !== 32'h100) $display("FAIL itype_ex_pc: got %h want 100", bus.ex_pc); else n_pass++;
    n_chk++; if (bus.ig_sel !== IG_I_TYPE) $display("FAIL itype_ig_sel: got %0d want %0d", bus.ig_sel, IG_I_TYPE); else n_pass++;
    n_chk++; if (gen_imm !== 32'hFFFF_FFFF) $display("FAIL itype_imm: got %h want ffffffff", gen_imm); else n_pass++;
    step();
    #1;
    n_chk++; if (bus.ex_valid !== 1'b0) $display("FAIL itype_after_valid: got %b want 0", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.ig_sel !== IG_DISABLED) $display("FAIL itype_after_sel: got %0d want %0d", bus.ig_sel, IG_DISABLED); else n_pass++;
    n_chk++; if (gen_imm !== 32'hFFFF_FFFF) $display("FAIL itype_imm_hold: got %h want ffffffff", gen_imm); else n_pass++;
  endtask

  task automatic test_backpressure();
    ig_sel_t exp_sel;
    send(32'h0011_2223, 32'h104, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      // Offer a competing instruction; it must not be taken while EX stalls.
      send(32'h0050_0293, 32'h108, 1'b0);
      #1;
      exp_sel = (i == 0) ? IG_S_TYPE : IG_DISABLED;
      n_chk++; if (bus.ex_valid !== 1'b1) $display("FAIL bp_ex_valid[%0d]: got %b want 1", i, bus.ex_valid); else n_pass++;
      n_chk++; if (bus.ex_inst !== 32'h0011_2223) $display("FAIL bp_ex_inst[%0d]: got %h want 00112223", i, bus.ex_inst); else n_pass++;
      n_chk++; if (bus.ex_pc !== 32'h104) $display("FAIL bp_ex_pc[%0d]: got %h want 104", i, bus.ex_pc); else n_pass++;
      n_chk++; if (bus.if_ready !== 1'b0) $display("FAIL bp_if_ready[%0d]: got %b want 0", i, bus.if_ready); else n_pass++;
      n_chk++; if (bus.ig_sel !== exp_sel) $display("FAIL bp_ig_sel[%0d]: got %0d want %0d", i, bus.ig_sel, exp_sel); else n_pass++;
      n_chk++; if (gen_imm !== 32'h4) $display("FAIL bp_imm[%0d]: got %h want 4", i, gen_imm); else n_pass++;
      step();
    end
    idle();
    #1;
    n_chk++; if (bus.ex_valid !== 1'b1) $display("FAIL bp_issue_valid: got %b want 1", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.if_ready !== 1'b1) $display("FAIL bp_issue_if_ready: got %b want 1", bus.if_ready); else n_pass++;
    step();
    #1;
    n_chk++; if (bus.ex_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", bus.ex_valid); else n_pass++;
  endtask

  task automatic test_load_use();
    send(32'h0000_2283, 32'h200, 1'b1);
    step();
    send(32'h0072_8333, 32'h204, 1'b1);
    #1;
    n_chk++; if (bus.ex_inst !== 32'h0000_2283 || bus.ex_valid !== 1'b1) $display("FAIL lu_load_issue: got v=%b %h want v=1 00002283", bus.ex_valid, bus.ex_inst); else n_pass++;
    step();
    idle();
    #1;
    n_chk++; if (bus.ex_valid !== 1'b0) $display("FAIL lu_bubble: got %b want 0", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.if_ready !== 1'b0) $display("FAIL lu_bubble_if_ready: got %b want 0", bus.if_ready); else n_pass++;
    step();
    #1;
    n_chk++; if (bus.ex_valid !== 1'b1) $display("FAIL lu_use_valid: got %b want 1", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.ex_inst !== 32'h0072_8333) $display("FAIL lu_use_inst: got %h want 00728333", bus.ex_inst); else n_pass++;
    n_chk++; if (bus.ex_pc !== 32'h204) $display("FAIL lu_use_pc: got %h want 204", bus.ex_pc); else n_pass++;
    step();
    #1;
    n_chk++; if (bus.ex_valid !== 1'b0) $display("FAIL lu_drained: got %b want 0", bus.ex_valid); else n_pass++;
  endtask

  task automatic test_rd_x0();
    send(32'h0000_2003, 32'h220, 1'b1);
    step();
    send(32'h0070_0333, 32'h224, 1'b1);
    #1;
    n_chk++; if (bus.ex_inst !== 32'h0000_2003) $display("FAIL x0_load_inst: got %h want 00002003", bus.ex_inst); else n_pass++;
    step();
    idle();
    #1;
    n_chk++; if (bus.ex_valid !== 1'b1) $display("FAIL x0_no_bubble: got %b want 1", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.ex_inst !== 32'h0070_0333) $display("FAIL x0_use_inst: got %h want 00700333", bus.ex_inst); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [3] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    send(prog[0], 32'h400, 1'b1);
    step();
    for (int k = 1; k <= 3; k++) begin
      if (k < 3) send(prog[k], 32'h400 + 32'(4 * k), 1'b1);
      else       idle();
      #1;
      n_chk++; if (bus.ex_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", k, bus.ex_valid); else n_pass++;
      n_chk++; if (bus.ex_inst !== prog[k-1]) $display("FAIL b2b_inst[%0d]: got %h want %h", k, bus.ex_inst, prog[k-1]); else n_pass++;
      n_chk++; if (bus.ig_sel !== IG_I_TYPE) $display("FAIL b2b_sel[%0d]: got %0d want %0d", k, bus.ig_sel, IG_I_TYPE); else n_pass++;
      n_chk++; if (gen_imm !== 32'(k)) $display("FAIL b2b_imm[%0d]: got %h want %h", k, gen_imm, k); else n_pass++;
      step();
    end
    #1;
    n_chk++; if (bus.ex_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", bus.ex_valid); else n_pass++;
  endtask

  typedef struct {
    logic [31:0] inst;
    ig_sel_t     sel;
    logic [31:0] imm;
    logic        ill;
    logic        chk_imm;
  } dec_vec_t;

  task automatic test_decode();
    dec_vec_t vec [6] = '{
      '{32'h1234_52B7, IG_U_TYPE,   32'h1234_5000, 1'b0, 1'b1},
      '{32'h0080_00EF, IG_J_TYPE,   32'h0000_0008, 1'b0, 1'b1},
      '{32'hFE00_0EE3, IG_B_TYPE,   32'hFFFF_FFFC, 1'b0, 1'b1},
      '{32'h0072_8333, IG_DISABLED, 32'h0,         1'b0, 1'b0},
      '{32'h0000_000F, IG_DISABLED, 32'h0,         1'b0, 1'b0},
      '{32'h0000_007F, IG_DISABLED, 32'h0,         1'b1, 1'b0}
    };
    for (int i = 0; i < 6; i++) begin
      send(vec[i].inst, 32'h500 + 32'(4 * i), 1'b1);
      step();
      idle();
      #1;
      n_chk++; if (bus.ex_valid !== 1'b1) $display("FAIL dec_valid[%0d]: got %b want 1", i, bus.ex_valid); else n_pass++;
      n_chk++; if (bus.ig_sel !== vec[i].sel) $display("FAIL dec_sel[%0d]: got %0d want %0d", i, bus.ig_sel, vec[i].sel); else n_pass++;
      n_chk++; if (bus.ex_illegal !== vec[i].ill) $display("FAIL dec_illegal[%0d]: got %b want %b", i, bus.ex_illegal, vec[i].ill); else n_pass++;
      if (vec[i].chk_imm) begin
        n_chk++; if (gen_imm !== vec[i].imm) $display("FAIL dec_imm[%0d]: got %h want %h", i, gen_imm, vec[i].imm); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_flush_hold();
    send(32'h0011_2223, 32'h300, 1'b0);
    step();
    idle();
    bus.ex_ready = 1'b0;
    #1;
    n_chk++; if (bus.ex_valid !== 1'b1) $display("FAIL fl_held: got %b want 1", bus.ex_valid); else n_pass++;
    step();
    send(32'h0050_0293, 32'h304, 1'b0);
    bus.flush = 1'b1;
    #1;
    n_chk++; if (bus.ex_valid !== 1'b0) $display("FAIL fl_ex_valid: got %b want 0", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.if_ready !== 1'b0) $display("FAIL fl_if_ready: got %b want 0", bus.if_ready); else n_pass++;
    step();
    send(32'h0050_0293, 32'h308, 1'b1);
    #1;
    n_chk++; if (bus.ex_valid !== 1'b0) $display("FAIL fl_empty_valid: got %b want 0", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.if_ready !== 1'b1) $display("FAIL fl_empty_ready: got %b want 1", bus.if_ready); else n_pass++;
    step();
    idle();
    #1;
    n_chk++; if (bus.ex_valid !== 1'b1) $display("FAIL fl_next_valid: got %b want 1", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.ex_inst !== 32'h0050_0293) $display("FAIL fl_next_inst: got %h want 00500293", bus.ex_inst); else n_pass++;
    n_chk++; if (bus.ex_pc !== 32'h308) $display("FAIL fl_next_pc: got %h want 308", bus.ex_pc); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    send(32'h0011_2223, 32'h600, 1'b0);
    step();
    idle();
    bus.ex_ready = 1'b0;
    #1;
    n_chk++; if (bus.ex_valid !== 1'b1) $display("FAIL rmid_held: got %b want 1", bus.ex_valid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.ex_valid !== 1'b0) $display("FAIL rmid_ex_valid: got %b want 0", bus.ex_valid); else n_pass++;
    n_chk++; if (bus.if_ready !== 1'b1) $display("FAIL rmid_if_ready: got %b want 1", bus.if_ready); else n_pass++;
    n_chk++; if (bus.ig_d !== 25'd0) $display("FAIL rmid_ig_d: got %h want 0", bus.ig_d); else n_pass++;
    step();
    rst_n = 1'b1;
    bus.ex_ready = 1'b1;
    step();
    #1;
    n_chk++; if (bus.ex_valid !== 1'b0) $display("FAIL rmid_after: got %b want 0", bus.ex_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_itype();
    test_backpressure();
    test_load_use();
    test_rd_x0();
    test_back_to_back();
    test_decode();
    test_flush_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
